// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter.
// Inhibits the bus, issues a start bit, then shifts out one byte (LSB first),
// an odd parity bit and a stop bit on device clock falling edges. Finally it
// checks the device acknowledge bit and waits for the bus to go idle.
// Optional feature macro: PS2_TX_TIMEOUT_EN adds a watchdog that aborts a
// transfer when the device stops clocking.
//
// Request handshake: tx_req is a one-cycle request that is accepted only while
// busy=0, and tx_data is captured in that cycle. busy rises in the next cycle
// and falls in the same cycle as the done/ack_error/timeout pulse. Requests
// made while busy=1 are dropped.
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       timeout
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic          clk_meta, clk_sync, clk_prev;
  logic          dat_meta, dat_sync;
  logic          fall;
  logic [7:0]    data_q;
  logic          parity_q;
  logic [3:0]    bit_cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    frame;
  logic [IW-1:0] inh_cnt;
  logic          ack_ok;
  logic          busy_q, done_q, ack_error_q;
  logic          done_set, nack_set;

  // Two-flop synchronisers; lines idle high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk_in;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= ps2_dat_in;
      dat_sync <= dat_meta;
    end
  end

  assign fall = clk_prev & ~clk_sync;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wd_cnt;
  logic          wd_active;
  logic          wd_expire;
  logic          timeout_q;
  logic          tout_set;

  assign wd_active = (state == START) || (state == SEND) ||
                     (state == ACK) || (state == WAIT_IDLE);
  assign wd_expire = wd_active && !fall && (wd_cnt == TO_LAST);

  // Watchdog: counts cycles since the last device falling edge while the device owns the clock.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wd_cnt <= '0;
    end else if (fall || !wd_active) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + TW'(1);
    end
  end

  // Timeout pulse register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tout_set;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign frame   = {parity_q, data_q};
  assign bit_idx = bit_cnt - 4'd1;

  // Next-state, open-drain line controls and status pulse requests.
  always_comb begin
    state_nxt  = state;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    done_set   = 1'b0;
    nack_set   = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    tout_set   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (tx_req) state_nxt = INHIBIT;
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_cnt == INH_LAST) begin
          ps2_dat_oe = 1'b1;
          state_nxt  = START;
        end
      end
      START: begin
        ps2_dat_oe = 1'b1;
        if (fall) state_nxt = SEND;
      end
      SEND: begin
        // bit_cnt = falling edges seen: 1..8 data bits, 9 parity; edge 10 releases the line.
        if (bit_cnt != 4'd0 && bit_cnt <= 4'd9) ps2_dat_oe = ~frame[bit_idx];
        if (fall && bit_cnt == 4'd9) state_nxt = ACK;
      end
      ACK: begin
        if (fall) begin
          state_nxt = WAIT_IDLE;
          nack_set  = dat_sync;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          state_nxt = IDLE;
          done_set  = ack_ok;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if (wd_expire) begin
      state_nxt = IDLE;
      done_set  = 1'b0;
      nack_set  = 1'b0;
      tout_set  = 1'b1;
    end
`endif
  end

  // Datapath: byte/parity capture, inhibit and bit counters, ack flag, status registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      data_q      <= 8'd0;
      parity_q    <= 1'b0;
      bit_cnt     <= 4'd0;
      inh_cnt     <= '0;
      ack_ok      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_error_q <= 1'b0;
    end else begin
      busy_q      <= (state_nxt != IDLE);
      done_q      <= done_set;
      ack_error_q <= nack_set;
      case (state)
        IDLE: begin
          if (tx_req) begin
            data_q   <= tx_data;
            parity_q <= ~^tx_data;
            bit_cnt  <= 4'd0;
            inh_cnt  <= '0;
            ack_ok   <= 1'b0;
          end
        end
        INHIBIT: inh_cnt <= inh_cnt + IW'(1);
        START:   if (fall) bit_cnt <= 4'd1;
        SEND:    if (fall) bit_cnt <= bit_cnt + 4'd1;
        ACK:     if (fall) ack_ok <= ~dat_sync;
        default: ;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_error = ack_error_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Testbench for ps2_host_transmitter with a behavioural PS/2 device model.
module tb_ps2_host_transmitter;

  localparam int INH = 40;
  localparam int TO  = 300;
  localparam int HP  = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       clk_line, dat_line;
  logic       ps2_clk_oe, ps2_dat_oe, busy, done, ack_error, timeout;

  assign clk_line = ~ps2_clk_oe & dev_clk;
  assign dat_line = ~ps2_dat_oe & dev_dat;

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .ack_error  (ack_error),
    .timeout    (timeout)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  // ---------------- status monitor ----------------
  int cyc = 0, done_n = 0, nack_n = 0, tout_n = 0, tout_cyc = 0;
  int excl_err = 0, len_err = 0, done_busy_err = 0, oe_err = 0;
  logic done_p = 1'b0, nack_p = 1'b0, tout_p = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_n++;
      if (busy) done_busy_err++;
    end
    if (ack_error) nack_n++;
    if (timeout) begin
      tout_n++;
      tout_cyc = cyc;
    end
    if (int'(done) + int'(ack_error) + int'(timeout) > 1) excl_err++;
    if ((done && done_p) || (ack_error && nack_p) || (timeout && tout_p)) len_err++;
    if (ps2_clk_oe && !busy) oe_err++;
    done_p = done;
    nack_p = ack_error;
    tout_p = timeout;
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_req  = 1'b1;
    @(negedge clk);
    tx_req  = 1'b0;
    tx_data = 8'($urandom_range(0, 255));
  endtask

  // Device model: checks the inhibit/start phase, then clocks out `edges` clocks,
  // sampling the data line on each rising edge.
  task automatic device(input bit ack, input int edges, output logic [9:0] frame,
                        output int fall3_cyc);
    int n, inh, dhi;
    frame = '0;
    fall3_cyc = 0;
    n = 0;
    while (!ps2_clk_oe && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("inhibit_seen", 32'(n < 500), 32'd1);
    inh = 0;
    dhi = 0;
    while (ps2_clk_oe && inh < INH * 4) begin
      inh++;
      if (ps2_dat_oe) dhi++;
      @(negedge clk);
    end
    check("inhibit_len", 32'(inh), 32'(INH));
    check("inhibit_dat_cycles", 32'(dhi), 32'd1);
    check("start_bit", 32'(ps2_dat_oe), 32'd1);
    for (int e = 1; e <= edges; e++) begin
      repeat (HP) @(negedge clk);
      dev_clk = 1'b0;
      if (e == 3) fall3_cyc = cyc;
      repeat (HP) @(negedge clk);
      if (e <= 10) frame[e-1] = dat_line;
      dev_clk = 1'b1;
      if (e == 10) begin
        repeat (HP / 2) @(negedge clk);
        dev_dat = ack ? 1'b0 : 1'b1;
      end
      if (e == 11) dev_dat = 1'b1;
    end
  endtask

  task automatic wait_not_busy(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack, input bit inject);
    int d0, n0, f3;
    logic [9:0] got;
    logic [9:0] exp;
    d0 = done_n;
    n0 = nack_n;
    exp_q.push_back({1'b1, odd_par(d), d});
    send_req(d);
    fork
      device(ack, 11, got, f3);
      begin
        if (inject) begin
          repeat (10) @(negedge clk);
          tx_data = 8'h55;
          tx_req  = 1'b1;
          @(negedge clk);
          tx_req  = 1'b0;
        end
      end
    join
    exp = exp_q.pop_front();
    check($sformatf("frame_%02h", d), 32'(got), 32'(exp));
    wait_not_busy("busy_release");
    repeat (2) @(negedge clk);
    check($sformatf("done_count_%02h", d), 32'(done_n - d0), ack ? 32'd1 : 32'd0);
    check($sformatf("nack_count_%02h", d), 32'(nack_n - n0), ack ? 32'd0 : 32'd1);
  endtask

  // ---------------- global time bound ----------------
  initial begin
    #2ms;
    $display("FAIL sim_time_limit total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    int s_done, s_nack, s_tout, f3;
    logic [9:0] got;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ack_error", 32'(ack_error), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    resetN = 1'b1;
    repeat (3) @(negedge clk);

    // main function: 0xED with a second request injected, parity corners, random bytes
    run_xfer(8'hED, 1'b1, 1'b1);
    run_xfer(8'h01, 1'b1, 1'b0);
    run_xfer(8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) run_xfer(8'($urandom_range(0, 255)), 1'b1, 1'b0);

    // missing acknowledge
    run_xfer(8'h3C, 1'b0, 1'b0);

    // reset in the middle of a transfer after 4 device clocks
    send_req(8'h00);
    device(1'b1, 4, got, f3);
    check("pre_reset_dat_oe", 32'(ps2_dat_oe), 32'd1);
    check("pre_reset_busy", 32'(busy), 32'd1);
    s_done = done_n;
    s_nack = nack_n;
    s_tout = tout_n;
    #3;
    resetN = 1'b0;
    #1;
    check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("reset_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_no_pulses", 32'((done_n - s_done) + (nack_n - s_nack) + (tout_n - s_tout)), 32'd0);
    run_xfer(8'hED, 1'b1, 1'b0);

`ifdef PS2_TX_TIMEOUT_EN
    // device stops clocking after edge 3
    begin
      int n;
      s_done = done_n;
      s_tout = tout_n;
      send_req(8'hA5);
      device(1'b1, 3, got, f3);
      n = 0;
      while (tout_n == s_tout && n < TO * 3) begin
        @(negedge clk);
        n++;
      end
      check("timeout_count", 32'(tout_n - s_tout), 32'd1);
      check("timeout_delay", 32'((tout_cyc - f3) >= TO && (tout_cyc - f3) <= TO + 5), 32'd1);
      check("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("timeout_dat_oe", 32'(ps2_dat_oe), 32'd0);
      check("timeout_busy", 32'(busy), 32'd0);
      check("timeout_no_done", 32'(done_n - s_done), 32'd0);
    end
`else
    check("no_timeout_pulses", 32'(tout_n), 32'd0);
`endif

    // global invariants
    check("pulse_exclusive", 32'(excl_err), 32'd0);
    check("pulse_one_cycle", 32'(len_err), 32'd0);
    check("busy_low_at_done", 32'(done_busy_err), 32'd0);
    check("clk_oe_only_busy", 32'(oe_err), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
